pps_fetch_buf: RTL and testbench

//  Parametrised instruction-fetch stage with a prefetch queue. It generates

---
 rtl/pps_fetch_buf_if.sv | 33 +++
 rtl/pps_fetch_buf.sv | 127 ++++++++++++
 tb/tb_pps_fetch_buf.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pps_fetch_buf_if.sv
// Fetch-stage bus bundle: redirect control, instruction memory port
// and the decode-side valid/ready queue head.
interface pps_fetch_buf_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          id_valid;
    logic [DW-1:0] id_inst;
    logic [AW-1:0] id_pc;
    logic          id_ready;
    logic [CW-1:0] q_count;

    // Fetch stage side
    modport master (
        input  redirect, redirect_pc, mem_ack, mem_rdata, id_ready,
        output mem_req, mem_addr, id_valid, id_inst, id_pc, q_count
    );

    // Memory / decode / control side
    modport slave (
        output redirect, redirect_pc, mem_ack, mem_rdata, id_ready,
        input  mem_req, mem_addr, id_valid, id_inst, id_pc, q_count
    );
endinterface

// File: rtl/pps_fetch_buf.sv
// Instruction fetch stage: sequential address generator issuing one
// outstanding memory request at a time into a DEPTH-entry prefetch queue.
// A redirect flushes the queue; a request already on the bus when the
// redirect arrives is allowed to complete and its data is dropped.
module pps_fetch_buf #(
    parameter int            AW     = 32,
    parameter int            DW     = 32,
    parameter int            DEPTH  = 4,
    parameter logic [AW-1:0] RST_PC = '0,
    parameter int            PC_INC = 4
) (
    input  logic             clk,
    input  logic             rst,
    pps_fetch_buf_if.master  bus
);
    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [AW-1:0] INC  = AW'(PC_INC);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t        state;
    logic [AW-1:0] fpc;        // next address to fetch
    logic [AW-1:0] req_addr;   // address on the bus (held until ack)
    logic          req;

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] inst_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    logic          ack, pop, push;
    logic [CW-1:0] cnt_after_pop, cnt_after;

    // A redirect voids any pop and any push in its cycle.
    assign ack           = req & bus.mem_ack;
    assign pop           = (count != '0) & bus.id_ready & ~bus.redirect;
    assign push          = (state == S_WAIT) & ack & ~bus.redirect;
    assign cnt_after_pop = count - CW'(pop);
    assign cnt_after     = cnt_after_pop + CW'(push);

    assign bus.mem_req  = req;
    assign bus.mem_addr = req_addr;
    assign bus.q_count  = count;
    assign bus.id_valid = (count != '0);
    // Head is forced to zero when empty so stale storage never shows.
    assign bus.id_inst  = (count != '0) ? inst_mem[rd_ptr] : '0;
    assign bus.id_pc    = (count != '0) ? pc_mem[rd_ptr]   : '0;

    // Fetch FSM: issues a request only once a queue slot is guaranteed,
    // so a returning word can always be pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            fpc      <= RST_PC;
            req_addr <= '0;
            req      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.redirect) begin
                        state    <= S_WAIT;
                        req      <= 1'b1;
                        fpc      <= bus.redirect_pc;
                        req_addr <= bus.redirect_pc;
                    end else if (cnt_after_pop < FULL) begin
                        state    <= S_WAIT;
                        req      <= 1'b1;
                        req_addr <= fpc;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect) begin
                        fpc <= bus.redirect_pc;
                        if (ack) req_addr <= bus.redirect_pc;
                        else     state    <= S_DROP;
                    end else if (ack) begin
                        fpc <= fpc + INC;
                        if (cnt_after < FULL) begin
                            req_addr <= fpc + INC;
                        end else begin
                            state <= S_IDLE;
                            req   <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    // Stale request still on the bus; keep its address.
                    if (bus.redirect) fpc <= bus.redirect_pc;
                    if (ack) begin
                        state    <= S_WAIT;
                        req_addr <= bus.redirect ? bus.redirect_pc : fpc;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= cnt_after;
        end
    end

    // Queue storage: written on push, no reset needed (head is gated).
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= bus.mem_rdata;
            pc_mem[wr_ptr]   <= fpc;
        end
    end
endmodule

// File: tb/tb_pps_fetch_buf.sv
// Self-checking bench for pps_fetch_buf: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_pps_fetch_buf;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pps_fetch_buf_if #(.AW(32), .DW(32), .DEPTH(DEPTH)) bus();

    pps_fetch_buf #(.AW(32), .DW(32), .DEPTH(DEPTH), .RST_PC(32'h0), .PC_INC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // Instruction memory returns a word derived from its address.
    always_comb bus.mem_rdata = f(bus.mem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = '0;
        bus.mem_ack = 1'b0;  bus.id_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step();
        rst = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = '0;
        bus.mem_ack = 1'b1;  bus.id_ready = 1'b1;
        step();
        step();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", bus.mem_req); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", bus.id_valid); end
        checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.q_count); end
        checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%0h exp=0", bus.id_pc); end
        checks++; if (bus.id_inst !== 32'h0) begin errors++; $display("FAIL rst_inst got=%0h exp=0", bus.id_inst); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] epc;
        do_reset();
        bus.mem_ack = 1'b1; bus.id_ready = 1'b1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL s_c0_req got=%0h exp=0", bus.mem_req); end
        step();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL s_c1_req got=%0h/%0h exp=1/0", bus.mem_req, bus.mem_addr); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL s_c1_valid got=%0h exp=0", bus.id_valid); end
        for (int k = 2; k < 10; k++) begin
            step();
            epc = 32'(4 * (k - 2));
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'(4 * (k - 1))) begin errors++; $display("FAIL s_addr c%0d got=%0h exp=%0h", k, bus.mem_addr, 4 * (k - 1)); end
            checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== epc || bus.id_inst !== f(epc)) begin errors++; $display("FAIL s_head c%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, bus.id_valid, bus.id_pc, bus.id_inst, epc, f(epc)); end
        end
    endtask

    task automatic test_backpressure();
        int pushes = 0;
        do_reset();
        bus.mem_ack = 1'b1; bus.id_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.mem_req) pushes++;
        end
        checks++; if (pushes != DEPTH) begin errors++; $display("FAIL bp_pushes got=%0d exp=%0d", pushes, DEPTH); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full got=%0h exp=0", bus.mem_req); end
        checks++; if (bus.q_count !== 3'd4) begin errors++; $display("FAIL bp_count got=%0d exp=4", bus.q_count); end
        checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL bp_head got=%0h exp=0", bus.id_pc); end
        bus.id_ready = 1'b1; bus.mem_ack = 1'b0;
        step();
        bus.id_ready = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin errors++; $display("FAIL bp_resume got=%0h/%0h exp=1/10", bus.mem_req, bus.mem_addr); end
        checks++; if (bus.q_count !== 3'd3 || bus.id_pc !== 32'h4) begin errors++; $display("FAIL bp_pop got=%0d/%0h exp=3/4", bus.q_count, bus.id_pc); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        bus.mem_ack = 1'b1; bus.id_ready = 1'b1;
        step();
        step();
        step();
        checks++; if (bus.mem_addr !== 32'h8) begin errors++; $display("FAIL rw_pre got=%0h exp=8", bus.mem_addr); end
        bus.mem_ack = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.q_count !== 3'd0 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL rw_flush got=%0d/%0h exp=0/0", bus.q_count, bus.id_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin errors++; $display("FAIL rw_hold i%0d got=%0h/%0h exp=1/8", i, bus.mem_req, bus.mem_addr); end
            if (i < 3) step();
        end
        bus.mem_ack = 1'b1;
        step();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL rw_new got=%0h/%0h exp=1/100", bus.mem_req, bus.mem_addr); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rw_drop got=%0h exp=0", bus.id_valid); end
        step();
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100 || bus.id_inst !== f(32'h100)) begin errors++; $display("FAIL rw_head got=%0h/%0h/%0h exp=1/100/%0h", bus.id_valid, bus.id_pc, bus.id_inst, f(32'h100)); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        bus.mem_ack = 1'b1; bus.id_ready = 1'b0;
        step();
        step();
        checks++; if (bus.mem_addr !== 32'h4 || bus.q_count !== 3'd1) begin errors++; $display("FAIL ra_pre got=%0h/%0d exp=4/1", bus.mem_addr, bus.q_count); end
        bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        step();
        bus.redirect = 1'b0; bus.mem_ack = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin errors++; $display("FAIL ra_addr got=%0h/%0h exp=1/200", bus.mem_req, bus.mem_addr); end
        checks++; if (bus.q_count !== 3'd0 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL ra_flush got=%0d/%0h exp=0/0", bus.q_count, bus.id_valid); end
        step();
        checks++; if (bus.q_count !== 3'd0) begin errors++; $display("FAIL ra_noword got=%0d exp=0", bus.q_count); end
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h200 || bus.q_count !== 3'd1) begin errors++; $display("FAIL ra_head got=%0h/%0h/%0d exp=1/200/1", bus.id_valid, bus.id_pc, bus.q_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.mem_ack = 1'b1; bus.id_ready = 1'b1;
        step();
        bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.mem_addr !== 32'hFFFF_FFF8 || bus.q_count !== 3'd0) begin errors++; $display("FAIL wr_tgt got=%0h/%0d exp=fffffff8/0", bus.mem_addr, bus.q_count); end
        step();
        checks++; if (bus.mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_fc got=%0h exp=fffffffc", bus.mem_addr); end
        step();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || bus.id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_zero got=%0h/%0h/%0h exp=1/0/fffffffc", bus.mem_req, bus.mem_addr, bus.id_pc); end
        step();
        checks++; if (bus.mem_addr !== 32'h4 || bus.id_pc !== 32'h0 || bus.id_valid !== 1'b1) begin errors++; $display("FAIL wr_next got=%0h/%0h/%0h exp=4/0/1", bus.mem_addr, bus.id_pc, bus.id_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.mem_ack = 1'b1; bus.id_ready = 1'b0;
        repeat (4) step();
        checks++; if (bus.q_count !== 3'd3 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'hC) begin errors++; $display("FAIL rm_pre got=%0d/%0h/%0h exp=3/1/c", bus.q_count, bus.mem_req, bus.mem_addr); end
        rst = 1'b1; bus.mem_ack = 1'b0;
        step();
        rst = 1'b0;
        checks++; if (bus.id_valid !== 1'b0 || bus.q_count !== 3'd0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL rm_clear got=%0h/%0d/%0h exp=0/0/0", bus.id_valid, bus.q_count, bus.mem_req); end
        step();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rm_restart got=%0h/%0h exp=1/0", bus.mem_req, bus.mem_addr); end
    endtask

    // Randomized run: the model is a plain queue of expected {pc,inst},
    // the next fetch address, and whether the bus request is stale.
    task automatic test_random();
        logic [31:0] pc_q[$];
        logic [31:0] inst_q[$];
        logic [31:0] exp_fpc = 32'h0;
        logic [31:0] prev_addr = 32'h0;
        logic [31:0] tgt;
        bit stale = 0, exp_req = 0, prev_req = 0, prev_ack = 0;
        bit pop_m, ack_m, req_now;
        int sz, pops = 0;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            sz = pc_q.size();
            checks++; if (bus.q_count !== 3'(sz) || bus.id_valid !== (sz != 0)) begin errors++; $display("FAIL rnd_count c%0d got=%0d/%0h exp=%0d", cyc, bus.q_count, bus.id_valid, sz); end
            if (sz != 0) begin
                checks++; if (bus.id_pc !== pc_q[0] || bus.id_inst !== inst_q[0]) begin errors++; $display("FAIL rnd_head c%0d got=%0h/%0h exp=%0h/%0h", cyc, bus.id_pc, bus.id_inst, pc_q[0], inst_q[0]); end
            end
            checks++; if (bus.mem_req !== exp_req) begin errors++; $display("FAIL rnd_req c%0d got=%0h exp=%0h", cyc, bus.mem_req, exp_req); end
            if (prev_req && !prev_ack) begin
                checks++; if (bus.mem_addr !== prev_addr) begin errors++; $display("FAIL rnd_hold c%0d got=%0h exp=%0h", cyc, bus.mem_addr, prev_addr); end
            end
            if (bus.mem_req && !stale) begin
                checks++; if (bus.mem_addr !== exp_fpc) begin errors++; $display("FAIL rnd_addr c%0d got=%0h exp=%0h", cyc, bus.mem_addr, exp_fpc); end
            end
            // Stimulus for this cycle
            req_now = bus.mem_req;
            bus.mem_ack = req_now && ($urandom_range(0, 2) != 0);
            bus.id_ready = ($urandom_range(0, 9) < 6);
            bus.redirect = ($urandom_range(0, 19) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
            bus.redirect_pc = tgt;
            // Model update for the coming edge
            pop_m = (sz != 0) && bus.id_ready && !bus.redirect;
            ack_m = req_now && bus.mem_ack;
            if (bus.redirect) exp_req = 1;
            else if (req_now) exp_req = (ack_m && !stale) ? ((sz - int'(pop_m) + 1) < DEPTH) : 1'b1;
            else exp_req = ((sz - int'(pop_m)) < DEPTH);
            prev_req = req_now; prev_ack = bus.mem_ack; prev_addr = bus.mem_addr;
            if (bus.redirect) begin
                pc_q.delete(); inst_q.delete();
                exp_fpc = tgt;
                stale = req_now && !bus.mem_ack;
            end else begin
                if (pop_m) begin void'(pc_q.pop_front()); void'(inst_q.pop_front()); pops++; end
                if (ack_m) begin
                    if (stale) stale = 0;
                    else begin
                        pc_q.push_back(exp_fpc); inst_q.push_back(f(exp_fpc));
                        exp_fpc = exp_fpc + 32'd4;
                    end
                end
            end
            step();
        end
        bus.redirect = 1'b0; bus.mem_ack = 1'b0; bus.id_ready = 1'b0;
        checks++; if (pops < 100) begin errors++; $display("FAIL rnd_progress got=%0d exp>=100", pops); end
    endtask

    initial begin
        bus.redirect = 1'b0; bus.redirect_pc = '0;
        bus.mem_ack = 1'b0;  bus.id_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
